mul_arbiter: RTL



---
 rtl/mul_pkg.sv | 20 ++
 rtl/rr_pick.sv | 34 +++
 rtl/mul_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the multiplier arbiter.
package mul_pkg;

  // Default operand width; the product is twice as wide.
  localparam int W_DEF  = 8;
  localparam int PW_DEF = 2 * W_DEF;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Width of the product for a given operand width.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] winner,
  output logic           any
);

  // Scan from the farthest candidate back to ptr so the closest one wins.
  always_comb begin : scan
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) winner = IDW'(idx);
    end
  end

  assign any = |req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = any && (winner == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one multiply unit among N
// requesters: grants a requester, starts the multiplier, waits for Ready
// and returns the product tagged with the requester id.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = W_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             mul_start,
  output logic [W-1:0]     mul_multiplicand,
  output logic [W-1:0]     mul_multiplier,
  input  logic             mul_ready,
  input  logic [2*W-1:0]   mul_product
);

  localparam int PW = prod_width(W);

  state_t         state;
  state_t         state_next;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] job_id;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  logic [N-1:0]   pick_grant;
  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic [IDW-1:0] ptr_inc;

  logic [W-1:0]   a_slice [N];
  logic [W-1:0]   b_slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_slice[gi] = a_in[gi*W +: W];
      assign b_slice[gi] = b_in[gi*W +: W];
    end
  endgenerate

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .grant  (pick_grant),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Pointer moves just past the winner so it becomes lowest priority.
  assign ptr_inc = (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;

  assign mul_multiplicand = op_a;
  assign mul_multiplier   = op_b;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus the state-decoded start and busy outputs.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pick_any) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        if (mul_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grant/capture in IDLE, result return at the end of WAIT; gnt and done
  // are single-cycle pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr     <= '0;
      job_id  <= '0;
      op_a    <= '0;
      op_b    <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      product <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (state == S_IDLE && pick_any) begin
        gnt    <= pick_grant;
        job_id <= pick_id;
        op_a   <= a_slice[pick_id];
        op_b   <= b_slice[pick_id];
        ptr    <= ptr_inc;
      end
      if (state == S_WAIT && mul_ready) begin
        product <= PW'(mul_product);
        done_id <= job_id;
        done    <= 1'b1;
      end
    end
  end

endmodule
